axi_mem_slave: RTL

AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

---
 rtl/mem_slave_pkg.sv | 19 +
 rtl/mem_line_array.sv | 31 +++
 rtl/axi_mem_slave.sv | 119 +++++++++++
 3 files changed

// File: rtl/mem_slave_pkg.sv
// Shared types and constants for the AXI line-memory slave.
// Line geometry and FSM encoding used by axi_mem_slave and mem_line_array.
package mem_slave_pkg;

  localparam int LINE_BITS     = 128;
  localparam int STRB_BITS     = 16;
  localparam int BYTE_OFS_BITS = 4;
  localparam int LAT_CNT_BITS  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2
  } state_t;

  typedef logic [LINE_BITS-1:0] line_t;
  typedef logic [STRB_BITS-1:0] strb_t;

endpackage

// File: rtl/mem_line_array.sv
// Byte-enabled line store: one synchronous write port, one combinational read port.
// Latency: write visible after the write edge; read is same-cycle. No backpressure.
module mem_line_array
  import mem_slave_pkg::*;
#(
  parameter  int DEPTH_LINES = 256,
  localparam int IDX_BITS    = $clog2(DEPTH_LINES)
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  line_t               wr_dat,
  input  strb_t               wr_strb,
  input  logic [IDX_BITS-1:0] rd_idx,
  output line_t               rd_dat
);

  line_t mem [DEPTH_LINES];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < STRB_BITS; b++) begin
        if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
      end
    end
  end

  assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/axi_mem_slave.sv
// Simplified AXI slave over a line array; writes take one IDLE cycle, reads return after READ_LAT.
// Readies are high only in IDLE; RVALID holds until RREADY. MEM_ADDR_CHECK_EN enables range checks.
module axi_mem_slave
  import mem_slave_pkg::*;
#(
  parameter int DEPTH_LINES = 256,
  parameter int READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ARADDR,
  input  logic        ARVALID,
  output logic        ARREADY,
  output line_t       RDATA,
  output logic        RVALID,
  input  logic        RREADY,
  input  logic [31:0] AWADDR,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  line_t       WDATA,
  input  strb_t       WSTRB,
  input  logic        WVALID,
  output logic        WREADY
);

  localparam int IDX_BITS = $clog2(DEPTH_LINES);
  localparam int IDX_TOP  = BYTE_OFS_BITS + IDX_BITS;

  state_t                  state, state_nxt;
  logic [LAT_CNT_BITS-1:0] lat_cnt;
  logic [IDX_BITS-1:0]     rd_idx;
  logic                    rd_oor;
  logic                    wr_pair_vld, wr_acc, rd_acc;
  logic                    aw_oor, ar_oor;
  line_t                   arr_rd_dat;

  assign wr_pair_vld = AWVALID & WVALID;
  assign wr_acc      = AWREADY & wr_pair_vld;
  assign rd_acc      = ARREADY & ARVALID;

`ifdef MEM_ADDR_CHECK_EN
  assign aw_oor = |AWADDR[31:IDX_TOP];
  assign ar_oor = |ARADDR[31:IDX_TOP];
  logic unused_ofs_bits;
  assign unused_ofs_bits = ^{AWADDR[BYTE_OFS_BITS-1:0], ARADDR[BYTE_OFS_BITS-1:0]};
`else
  assign aw_oor = 1'b0;
  assign ar_oor = 1'b0;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{AWADDR[31:IDX_TOP], AWADDR[BYTE_OFS_BITS-1:0],
                              ARADDR[31:IDX_TOP], ARADDR[BYTE_OFS_BITS-1:0]};
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rd_acc) state_nxt = (READ_LAT == 1) ? RD_RESP : RD_WAIT;
      RD_WAIT: if (lat_cnt == LAT_CNT_BITS'(1)) state_nxt = RD_RESP;
      RD_RESP: if (RREADY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ARREADY drops while a write pair is offered so the deferred read is never half-handshaken.
  always_comb begin
    ARREADY = 1'b0;
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    RVALID  = 1'b0;
    RDATA   = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          AWREADY = 1'b1;
          WREADY  = 1'b1;
          ARREADY = ~wr_pair_vld;
        end
        RD_RESP: begin
          RVALID = 1'b1;
          RDATA  = rd_oor ? '0 : arr_rd_dat;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                  lat_cnt <= '0;
    else if (rd_acc)          lat_cnt <= LAT_CNT_BITS'(READ_LAT - 1);
    else if (state == RD_WAIT) lat_cnt <= lat_cnt - LAT_CNT_BITS'(1);
  end

  // Writes are blocked until the read completes, so reading the captured line later
  // still returns the contents present at the AR handshake.
  always_ff @(posedge clk) begin
    if (rd_acc) begin
      rd_idx <= ARADDR[IDX_TOP-1:BYTE_OFS_BITS];
      rd_oor <= ar_oor;
    end
  end

  mem_line_array #(
    .DEPTH_LINES(DEPTH_LINES)
  ) u_array (
    .clk    (clk),
    .wr_en  (wr_acc & ~aw_oor),
    .wr_idx (AWADDR[IDX_TOP-1:BYTE_OFS_BITS]),
    .wr_dat (WDATA),
    .wr_strb(WSTRB),
    .rd_idx (rd_idx),
    .rd_dat (arr_rd_dat)
  );

endmodule
